// File: rtl/axi_rd_arb_pkg.sv
// Shared types for the MMU refill read arbiter.
// FSM state encoding and AXI constants used by the arbiter and its tests.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_rd_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping modulo n.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int n  = 3,
  parameter int iw = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]  req_i,
  input  logic [iw-1:0] ptr_i,
  output logic [n-1:0]  gnt_o,
  output logic [iw-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < n; k++) begin
      j = int'(ptr_i) + k;
      if (j >= n) j = j - n;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = iw'(j);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arb.sv
// Round-robin arbiter sharing one AXI4 read master among nreq refill requesters, one burst in flight.
// R beats are steered to the granted requester with no buffering; beat counting flags protocol errors.
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int nreq = 3,
  parameter int idw  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [nreq-1:0]        s_arvalid,
  output logic [nreq-1:0]        s_arready,
  input  logic [nreq-1:0][63:0]  s_araddr,
  input  logic [nreq-1:0][7:0]   s_arlen,
  input  logic [nreq-1:0][2:0]   s_arsize,
  output logic [nreq-1:0]        s_rvalid,
  input  logic [nreq-1:0]        s_rready,
  output logic [63:0]            s_rdata,
  output logic                   s_rlast,
  output logic [1:0]             s_rresp,
  output logic [idw-1:0]         m_axi_arid,
  output logic [63:0]            m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arlock,
  output logic [3:0]             m_axi_arcache,
  output logic [2:0]             m_axi_arprot,
  output logic [3:0]             m_axi_arqos,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [idw-1:0]         m_axi_rid,
  input  logic [63:0]            m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  output logic                   busy,
  output logic                   err
);

  localparam int gw = $clog2(nreq);

  arb_state_t      state_q;
  logic [gw-1:0]   rr_ptr_q, rr_ptr_d;
  logic [gw-1:0]   g_q;
  logic [63:0]     araddr_q;
  logic [7:0]      arlen_q;
  logic [2:0]      arsize_q;
  logic [7:0]      beat_q, beat_d;
  logic            err_q, err_d;

  logic [nreq-1:0] pick_gnt;
  logic [gw-1:0]   pick_idx;
  logic            pick_any;
  logic [nreq-1:0] g_oh;
  logic            r_hs;

  rr_pick #(.n(nreq), .iw(gw)) u_pick (
    .req_i (s_arvalid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign g_oh = {{(nreq-1){1'b0}}, 1'b1} << g_q;
  assign r_hs = (state_q == ARB_DATA) && m_axi_rvalid && m_axi_rready;

  always_comb begin
    rr_ptr_d = (pick_idx == gw'(nreq - 1)) ? '0 : pick_idx + gw'(1);
    beat_d   = beat_q + 8'd1;
    err_d    = err_q;
    // Error checks only qualify on a real beat handshake; the FSM keeps going regardless.
    if (r_hs) begin
      if (m_axi_rlast && (beat_q != arlen_q))        err_d = 1'b1;
      if (!m_axi_rlast && (beat_q == arlen_q))       err_d = 1'b1;
      if (m_axi_rid[gw-1:0] != g_q)                  err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      g_q      <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            g_q      <= pick_idx;
            araddr_q <= s_araddr[pick_idx];
            arlen_q  <= s_arlen[pick_idx];
            arsize_q <= s_arsize[pick_idx];
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (m_axi_arready) begin
            beat_q  <= '0;
            state_q <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (r_hs) begin
            beat_q <= beat_d;
            if (m_axi_rlast) state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign s_arready     = (state_q == ARB_IDLE) ? pick_gnt : '0;
  assign m_axi_arvalid = (state_q == ARB_ADDR);
  assign m_axi_arid    = {{(idw-gw){1'b0}}, g_q};
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;

  // Pure wiring on the R path so requester stalls reach the slave in the same cycle.
  assign m_axi_rready  = (state_q == ARB_DATA) && s_rready[g_q];
  assign s_rvalid      = ((state_q == ARB_DATA) && m_axi_rvalid) ? g_oh : '0;
  assign s_rdata       = m_axi_rdata;
  assign s_rlast       = m_axi_rlast;
  assign s_rresp       = m_axi_rresp;

  assign busy = (state_q != ARB_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: grant order, AR stall, R back-pressure, error flagging, reset mid-burst.
module tb_axi_rd_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       s_arvalid;
  logic [2:0]       s_arready;
  logic [2:0][63:0] s_araddr;
  logic [2:0][7:0]  s_arlen;
  logic [2:0][2:0]  s_arsize;
  logic [2:0]       s_rvalid;
  logic [2:0]       s_rready;
  logic [63:0]      s_rdata;
  logic             s_rlast;
  logic [1:0]       s_rresp;
  logic [7:0]       m_axi_arid;
  logic [63:0]      m_axi_araddr;
  logic [7:0]       m_axi_arlen;
  logic [2:0]       m_axi_arsize;
  logic [1:0]       m_axi_arburst;
  logic             m_axi_arlock;
  logic [3:0]       m_axi_arcache;
  logic [2:0]       m_axi_arprot;
  logic [3:0]       m_axi_arqos;
  logic             m_axi_arvalid;
  logic             m_axi_arready;
  logic [7:0]       m_axi_rid;
  logic [63:0]      m_axi_rdata;
  logic [1:0]       m_axi_rresp;
  logic             m_axi_rlast;
  logic             m_axi_rvalid;
  logic             m_axi_rready;
  logic             busy;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_rd_arb #(.nreq(3), .idw(8)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rresp(s_rresp),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present mask, expect grant exp_g, hold AR for stall cycles, then handshake.
  task automatic issue(input logic [2:0] mask, input int exp_g, input logic [63:0] addr,
                       input logic [7:0] len, input int stall);
    logic [2:0] oh;
    oh = 3'b001 << exp_g;
    for (int k = 0; k < 3; k++) begin
      s_araddr[k] = (k == exp_g) ? addr : (64'hDEAD_0000_0000_0000 | 64'(k));
      s_arlen[k]  = (k == exp_g) ? len : 8'hEE;
      s_arsize[k] = (k == exp_g) ? 3'd3 : 3'd1;
    end
    s_arvalid = mask;
    #1;
    chk("s_arready_grant", 64'(s_arready), 64'(oh));
    chk("idle_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    tick();
    s_arvalid[exp_g] = 1'b0;
    for (int c = 0; c <= stall; c++) begin
      #1;
      chk("arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("arid", 64'(m_axi_arid), 64'(exp_g));
      chk("araddr", m_axi_araddr, addr);
      chk("arlen", 64'(m_axi_arlen), 64'(len));
      chk("arsize", 64'(m_axi_arsize), 64'd3);
      chk("arburst", 64'(m_axi_arburst), 64'd1);
      chk("addr_s_arready", 64'(s_arready), 64'd0);
      if (c == stall) m_axi_arready = 1'b1;
      tick();
    end
    m_axi_arready = 1'b0;
  endtask

  // Drive nbeats R beats with rlast on beat last_at; optional requester stall on odd beats.
  task automatic data_phase(input int g, input int nbeats, input int last_at,
                            input logic [7:0] rid, input bit stall);
    logic [2:0] oh;
    oh = 3'b001 << g;
    s_rready = 3'b111;
    for (int i = 0; i < nbeats; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 64'hDA7A_0000_0000_0000 | 64'(i);
      m_axi_rlast  = (i == last_at);
      m_axi_rid    = rid;
      m_axi_rresp  = 2'b00;
      if (stall && (i % 2 == 1)) begin
        s_rready[g] = 1'b0;
        #1;
        chk("stall_rready", 64'(m_axi_rready), 64'd0);
        chk("stall_s_rvalid", 64'(s_rvalid), 64'(oh));
        tick();
        s_rready[g] = 1'b1;
      end
      #1;
      chk("s_rvalid", 64'(s_rvalid), 64'(oh));
      chk("m_rready", 64'(m_axi_rready), 64'd1);
      chk("s_rdata", s_rdata, 64'hDA7A_0000_0000_0000 | 64'(i));
      chk("s_rlast", 64'(s_rlast), 64'(i == last_at));
      chk("data_busy", 64'(busy), 64'd1);
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = 3'b111;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    rst = 1'b0;
    #1;

    // Single request from DCACHE
    issue(3'b010, 1, 64'h8000_0040, 8'd7, 0);
    data_phase(1, 8, 7, 8'd1, 1'b0);
    #1;
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // All three at once from rr_ptr 0, twice, then prove pointer wrapped to 0
    pulse_reset();
    issue(3'b111, 0, 64'h1000, 8'd1, 0); data_phase(0, 2, 1, 8'd0, 1'b0);
    issue(3'b110, 1, 64'h2000, 8'd1, 0); data_phase(1, 2, 1, 8'd1, 1'b0);
    issue(3'b100, 2, 64'h3000, 8'd1, 0); data_phase(2, 2, 1, 8'd2, 1'b0);
    issue(3'b111, 0, 64'h1100, 8'd0, 0); data_phase(0, 1, 0, 8'd0, 1'b0);
    issue(3'b110, 1, 64'h2100, 8'd0, 0); data_phase(1, 1, 0, 8'd1, 1'b0);
    issue(3'b100, 2, 64'h3100, 8'd0, 0); data_phase(2, 1, 0, 8'd2, 1'b0);
    issue(3'b101, 0, 64'h1200, 8'd0, 0); data_phase(0, 1, 0, 8'd0, 1'b0);

    // AR stall with competitors pending (ptr now 1)
    issue(3'b111, 1, 64'hCAFE_0080, 8'd3, 5);
    data_phase(1, 4, 3, 8'd1, 1'b0);

    // Requester back-pressure on alternate beats
    issue(3'b101, 2, 64'h4000, 8'd3, 0);
    data_phase(2, 4, 3, 8'd2, 1'b1);
    #1;
    chk("t4_busy_after", 64'(busy), 64'd0);
    chk("t4_err", 64'(err), 64'd0);

    // Early rlast
    s_arvalid = '0;
    issue(3'b001, 0, 64'h5000, 8'd3, 0);
    data_phase(0, 3, 2, 8'd0, 1'b0);
    #1;
    chk("t5_early_err", 64'(err), 64'd1);
    chk("t5_early_busy", 64'(busy), 64'd0);
    pulse_reset();
    chk("t5_err_cleared", 64'(err), 64'd0);

    // Wrong rid
    issue(3'b001, 0, 64'h6000, 8'd1, 0);
    data_phase(0, 2, 1, 8'd2, 1'b0);
    #1;
    chk("t5_rid_err", 64'(err), 64'd1);

    // Reset mid-burst
    pulse_reset();
    issue(3'b001, 0, 64'h7000, 8'd7, 0);
    data_phase(0, 2, 7, 8'd0, 1'b0);
    m_axi_rvalid = 1'b1;
    m_axi_rid    = 8'd0;
    rst = 1'b1;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_rready", 64'(m_axi_rready), 64'd0);
    chk("t6_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("t6_arvalid", 64'(m_axi_arvalid), 64'd0);
    tick();
    rst = 1'b0;
    m_axi_rvalid = 1'b0;
    #1;
    issue(3'b011, 0, 64'h7100, 8'd0, 0);
    data_phase(0, 1, 0, 8'd0, 1'b0);
    #1;
    chk("t6_final_busy", 64'(busy), 64'd0);
    chk("t6_final_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
